// File: rtl/wind_dir_avg.sv
// wind_dir_avg: block-averaged compass heading from a stream of signed angles.
//
// Each block of N = 2^LOG2N samples is unwrapped against its first sample, so
// blocks that straddle the +/-180 degree seam average correctly. The mean is
// folded into [0,360) and reported together with a variability flag raised
// when any sample of the block strayed more than VAR_THR from the reference.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   clear        synchronous block restart, also clears overrun
//   angle_valid  one-cycle strobe qualifying angle
//   angle        signed Q9.10 degrees, (-180,180]
//   heading      unsigned Q9.10 degrees, [0,360)
//   heading_deg  integer degrees, floor of heading
//   var_flag     max |delta| of the block exceeded VAR_THR
//   dir_valid    one-cycle pulse when heading/heading_deg/var_flag update
//   overrun      sticky: a sample arrived while the result was being computed
//
// state  | meaning
// IDLE   | waiting for the first sample of a block (becomes the reference)
// ACCUM  | accumulating unwrapped deltas against the reference
// DIV    | forming ref + acc/N
// WRAP   | folding the mean into [0,360), publishing the result
module wind_dir_avg #(
  parameter int                 LOG2N   = 4,
  parameter logic signed [18:0] VAR_THR = 19'sh0F000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               angle_valid,
  input  logic signed [18:0] angle,
  output logic        [18:0] heading,
  output logic        [8:0]  heading_deg,
  output logic               var_flag,
  output logic               dir_valid,
  output logic               overrun
);

  localparam int ACC_W = 20 + LOG2N;
  localparam int CNT_W = LOG2N + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2N) - 1);
  localparam logic signed [20:0] HALF_TURN = 21'sh2D000;
  localparam logic signed [20:0] FULL_TURN = 21'sh5A000;

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, WRAP} state_t;

  state_t                    state;
  logic signed [18:0]        ref_ang;
  logic signed [ACC_W-1:0]   acc;
  logic        [CNT_W-1:0]   count;
  logic signed [20:0]        maxabs;
  logic signed [20:0]        mean;

  logic signed [20:0] delta_raw;
  logic signed [20:0] delta;
  logic signed [20:0] abs_delta;
  logic signed [20:0] mean_next;
  logic signed [20:0] wrapped;
  logic signed [20:0] thr_ext;

  assign thr_ext   = $signed({{2{VAR_THR[18]}}, VAR_THR});
  assign delta_raw = $signed({{2{angle[18]}}, angle}) - $signed({{2{ref_ang[18]}}, ref_ang});

  // Unwrap into (-180,180]: exactly +180 is kept, exactly -180 becomes +180.
  always_comb begin
    delta = delta_raw;
    if (delta_raw > HALF_TURN)
      delta = delta_raw - FULL_TURN;
    else if (delta_raw <= -HALF_TURN)
      delta = delta_raw + FULL_TURN;
  end

  assign abs_delta = delta[20] ? -delta : delta;

  // Arithmetic shift floors toward -inf; the shifted mean delta always fits in 21 bits.
  assign mean_next = $signed({{2{ref_ang[18]}}, ref_ang}) + 21'(acc >>> LOG2N);

  always_comb begin
    wrapped = mean;
    if (mean < 0)
      wrapped = mean + FULL_TURN;
    else if (mean >= FULL_TURN)
      wrapped = mean - FULL_TURN;
  end

  assign heading_deg = heading[18:10];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ref_ang   <= '0;
      acc       <= '0;
      count     <= '0;
      maxabs    <= '0;
      mean      <= '0;
      heading   <= '0;
      var_flag  <= 1'b0;
      dir_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      dir_valid <= 1'b0;
      if (clear) begin
        // Clear wins over a coincident sample, which is dropped silently.
        state   <= IDLE;
        acc     <= '0;
        count   <= '0;
        maxabs  <= '0;
        overrun <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (angle_valid) begin
              ref_ang <= angle;
              acc     <= '0;
              maxabs  <= '0;
              count   <= CNT_W'(1);
              state   <= (LOG2N == 0) ? DIV : ACCUM;
            end
          end
          ACCUM: begin
            if (angle_valid) begin
              acc   <= acc + ACC_W'(delta);
              count <= count + CNT_W'(1);
              if (abs_delta > maxabs)
                maxabs <= abs_delta;
              if (count == LAST_CNT)
                state <= DIV;
            end
          end
          DIV: begin
            mean  <= mean_next;
            state <= WRAP;
            if (angle_valid)
              overrun <= 1'b1;
          end
          WRAP: begin
            heading   <= 19'(wrapped);
            var_flag  <= (maxabs > thr_ext);
            dir_valid <= 1'b1;
            state     <= IDLE;
            if (angle_valid)
              overrun <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wind_dir_avg.sv
module tb_wind_dir_avg;

  logic               clock;
  logic               reset;
  logic               clear;
  logic               angle_valid;
  logic signed [18:0] angle;
  logic        [18:0] heading;
  logic        [8:0]  heading_deg;
  logic               var_flag;
  logic               dir_valid;
  logic               overrun;

  typedef struct {
    logic [18:0] h;
    logic        v;
  } exp_t;

  exp_t sbq[$];
  int   tests_run = 0;
  int   fails     = 0;

  wind_dir_avg #(.LOG2N(4), .VAR_THR(19'sh0F000)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .angle_valid (angle_valid),
    .angle       (angle),
    .heading     (heading),
    .heading_deg (heading_deg),
    .var_flag    (var_flag),
    .dir_valid   (dir_valid),
    .overrun     (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: every dir_valid pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (reset && dir_valid) begin
      tests_run++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_dir_valid: heading=%h with no block pending", heading);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (heading !== e.h || heading_deg !== e.h[18:10] || var_flag !== e.v) begin
          fails++;
          $display("FAIL block_result: got heading=%h deg=%0d var=%b, want heading=%h deg=%0d var=%b",
                   heading, heading_deg, var_flag, e.h, e.h[18:10], e.v);
        end
      end
    end
  end

  task automatic send_block(input logic signed [18:0] a[16], input logic [18:0] eh,
                            input logic ev, input bit ovr_pulse);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock); #1;
      angle = a[i];
      angle_valid = 1'b1;
      if (i == 15) begin
        e.h = eh;
        e.v = ev;
        sbq.push_back(e);
      end
      @(posedge clock); #1;
      if (i == 15 && ovr_pulse) begin
        // Held high through the DIV cycle: must be dropped and flagged.
        @(posedge clock); #1;
      end
      angle_valid = 1'b0;
      repeat (2) @(posedge clock);
    end
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 20 && sbq.size() != 0; c++) @(posedge clock);
    if (sbq.size() != 0) begin
      tests_run++;
      fails++;
      $display("FAIL %s_timeout: %0d results pending, want 0", name, sbq.size());
      sbq.delete();
    end
    @(posedge clock); #1;
  endtask

  task automatic const_block(input logic signed [18:0] v, input logic [18:0] eh,
                             input logic ev, input bit ovr_pulse, input string name);
    logic signed [18:0] a[16];
    for (int i = 0; i < 16; i++) a[i] = v;
    send_block(a, eh, ev, ovr_pulse);
    wait_done(name);
  endtask

  task automatic check_zero(input string name);
    tests_run++;
    if (heading !== 19'h0 || heading_deg !== 9'd0 || var_flag !== 1'b0 ||
        dir_valid !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL %s: got heading=%h deg=%0d var=%b dv=%b ovr=%b, want all 0",
               name, heading, heading_deg, var_flag, dir_valid, overrun);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; angle_valid = 1'b0; angle = '0;
    repeat (3) @(posedge clock);
    #1 check_zero("reset_state");
    @(negedge clock) reset = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_constant();
    const_block(19'sh0B400, 19'h0B400, 1'b0, 1'b0, "const45");
    tests_run++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL const45_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_seam();
    logic signed [18:0] a[16];
    for (int i = 0; i < 16; i++) a[i] = (i % 2 == 0) ? 19'sh2CC00 : -19'sh2CC00;
    send_block(a, 19'h2D000, 1'b0, 1'b0);
    wait_done("seam");
  endtask

  task automatic test_negative();
    const_block(-19'sh16800, 19'h43800, 1'b0, 1'b0, "neg90");
  endtask

  task automatic test_split();
    logic signed [18:0] a[16];
    for (int i = 0; i < 16; i++) a[i] = (i < 8) ? 19'sh0 : 19'sh16800;
    send_block(a, 19'h0B400, 1'b1, 1'b0);
    wait_done("split_0_90");
    for (int i = 0; i < 16; i++) a[i] = (i < 8) ? 19'sh0 : 19'sh07800;
    send_block(a, 19'h03C00, 1'b0, 1'b0);
    wait_done("split_0_30");
  endtask

  // Reference +180 then 0s: every delta is exactly -180 and must become +180.
  task automatic test_boundary();
    logic signed [18:0] a[16];
    for (int i = 0; i < 16; i++) a[i] = (i == 0) ? 19'sh2D000 : 19'sh0;
    send_block(a, 19'h57300, 1'b1, 1'b0);
    wait_done("boundary_180");
  endtask

  task automatic test_overrun_clear();
    const_block(19'sh02800, 19'h02800, 1'b0, 1'b1, "ovr_block10");
    tests_run++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    const_block(19'sh05000, 19'h05000, 1'b0, 1'b0, "ovr_block20");
    tests_run++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
    // Clear coincides with a strobe: clear wins, sample dropped, no overrun.
    @(posedge clock); #1;
    clear = 1'b1; angle_valid = 1'b1; angle = 19'sh16800;
    @(posedge clock); #1;
    clear = 1'b0; angle_valid = 1'b0;
    tests_run++;
    if (overrun !== 1'b0 || heading !== 19'h05000 || heading_deg !== 9'd20 || dir_valid !== 1'b0) begin
      fails++;
      $display("FAIL clear_retain: got ovr=%b heading=%h deg=%0d dv=%b, want ovr=0 heading=05000 deg=20 dv=0",
               overrun, heading, heading_deg, dir_valid);
    end
    const_block(19'sh07800, 19'h07800, 1'b0, 1'b0, "after_clear30");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #1;
      angle = 19'sh19000; angle_valid = 1'b1;
      @(posedge clock); #1;
      angle_valid = 1'b0;
      @(posedge clock);
    end
    #3 reset = 1'b0;
    #1 check_zero("reset_mid_async");
    @(posedge clock); #1;
    check_zero("reset_mid_held");
    @(negedge clock) reset = 1'b1;
    const_block(-19'sh28000, 19'h32000, 1'b0, 1'b0, "post_reset200");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_constant();
    test_seam();
    test_negative();
    test_split();
    test_boundary();
    test_overrun_clear();
    test_reset_mid();
    repeat (4) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
